// File: rtl/hdmi_rom_pic_reader.sv
// hdmi_rom_pic_reader: tracks de/hs/vs timing, places a ROM picture window in the active area
// and emits window pixels merged with a background colour, three clocks behind the inputs.
module hdmi_rom_pic_reader #(
    parameter int                    ADDR_WIDTH = 16,
    parameter int                    DATA_WIDTH = 24,
    parameter int                    IMG_W      = 256,
    parameter int                    IMG_H      = 256,
    parameter int                    H_START    = 512,
    parameter int                    V_START    = 232,
    parameter logic [DATA_WIDTH-1:0] BG_COLOR   = '0,
    parameter int                    CNT_WIDTH  = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  de_in,
    input  logic                  hs_in,
    input  logic                  vs_in,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_data,
    output logic                  de_out,
    output logic                  hs_out,
    output logic                  vs_out,
    output logic [DATA_WIDTH-1:0] rgb_out,
    output logic                  frame_start
);
    localparam logic [CNT_WIDTH:0]    X_LO     = (CNT_WIDTH+1)'(H_START);
    localparam logic [CNT_WIDTH:0]    X_HI     = (CNT_WIDTH+1)'(H_START + IMG_W);
    localparam logic [CNT_WIDTH:0]    Y_LO     = (CNT_WIDTH+1)'(V_START);
    localparam logic [CNT_WIDTH:0]    Y_HI     = (CNT_WIDTH+1)'(V_START + IMG_H);
    localparam logic [CNT_WIDTH-1:0]  X_OFF    = CNT_WIDTH'(H_START);
    localparam logic [ADDR_WIDTH-1:0] ROW_STEP = ADDR_WIDTH'(IMG_W);

    logic [CNT_WIDTH-1:0]  r_x_cnt, r_y_cnt, w_y;
    logic [ADDR_WIDTH-1:0] r_row_base, w_row_base, w_addr;
    logic [1:0]            r_de_d, r_hs_d, r_vs_d, r_win_d, r_sync_d;
    logic                  r_synced, w_synced, w_vs_rise, w_de_fall;
    logic                  w_x_in, w_y_in, w_y_cnt_in, w_in_win;

    // A frame start overrides everything else on its cycle, so the pixel there is already line 0.
    always_comb begin
        w_vs_rise  = vs_in & ~r_vs_d[0];
        w_de_fall  = ~de_in & r_de_d[0];
        w_synced   = r_synced | w_vs_rise;
        w_y        = w_vs_rise ? '0 : r_y_cnt;
        w_row_base = w_vs_rise ? '0 : r_row_base;
        w_x_in     = ({1'b0, r_x_cnt} >= X_LO) && ({1'b0, r_x_cnt} < X_HI);
        w_y_in     = ({1'b0, w_y} >= Y_LO) && ({1'b0, w_y} < Y_HI);
        w_y_cnt_in = ({1'b0, r_y_cnt} >= Y_LO) && ({1'b0, r_y_cnt} < Y_HI);
        w_in_win   = w_synced & de_in & w_x_in & w_y_in;
        w_addr     = w_row_base + ADDR_WIDTH'(r_x_cnt - X_OFF);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_x_cnt     <= '0;
            r_y_cnt     <= '0;
            r_row_base  <= '0;
            r_synced    <= 1'b0;
            r_de_d      <= '0;
            r_hs_d      <= '0;
            r_vs_d      <= '0;
            r_win_d     <= '0;
            r_sync_d    <= '0;
            rom_addr    <= '0;
            de_out      <= 1'b0;
            hs_out      <= 1'b0;
            vs_out      <= 1'b0;
            rgb_out     <= BG_COLOR;
            frame_start <= 1'b0;
        end else begin
            r_x_cnt     <= de_in ? r_x_cnt + CNT_WIDTH'(1) : '0;
            r_y_cnt     <= w_vs_rise ? '0 : (w_de_fall ? r_y_cnt + CNT_WIDTH'(1) : r_y_cnt);
            r_row_base  <= w_vs_rise ? '0 : ((w_de_fall && w_y_cnt_in) ? r_row_base + ROW_STEP : r_row_base);
            r_synced    <= w_synced;
            r_de_d      <= {r_de_d[0], de_in};
            r_hs_d      <= {r_hs_d[0], hs_in};
            r_vs_d      <= {r_vs_d[0], vs_in};
            r_win_d     <= {r_win_d[0], w_in_win};
            r_sync_d    <= {r_sync_d[0], w_synced};
            rom_addr    <= w_in_win ? w_addr : rom_addr;
            de_out      <= r_de_d[1];
            hs_out      <= r_hs_d[1];
            vs_out      <= r_vs_d[1];
            rgb_out     <= r_win_d[1] ? rom_data : BG_COLOR;
            frame_start <= r_vs_d[1] & ~vs_out & r_sync_d[1];
        end
    end
endmodule

// File: tb/tb_hdmi_rom_pic_reader.sv
// tb_hdmi_rom_pic_reader: three reader instances (small window, clipped window, full-size default)
// share one timing stream; a frame/line/pixel model feeds a scoreboard checked by a monitor.
module tb_hdmi_rom_pic_reader;
    typedef struct packed {
        logic             de, hs, vs, fs;
        logic [2:0][23:0] rgb;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, de, hs, vs;
    logic [15:0] addr [3];
    logic [23:0] rdat [3];
    logic [23:0] rgb  [3];
    logic        deo [3], hso [3], vso [3], fso [3];

    int hs_p [3] = '{2, 6, 512};
    int vs_p [3] = '{1, 1, 232};
    int iw_p [3] = '{4, 4, 256};
    int ih_p [3] = '{2, 2, 256};

    exp_t        q[$];
    exp_t        me;
    logic [15:0] ea_next [3];
    logic [15:0] ea_cur  [3];
    int          mx, my;
    bit          synced, pde, pvs;
    int          checks = 0, errors = 0;

    always #5 clk = ~clk;

    hdmi_rom_pic_reader #(.IMG_W(4), .IMG_H(2), .H_START(2), .V_START(1)) u0 (
        .clk(clk), .rst(rst), .de_in(de), .hs_in(hs), .vs_in(vs), .rom_addr(addr[0]), .rom_data(rdat[0]),
        .de_out(deo[0]), .hs_out(hso[0]), .vs_out(vso[0]), .rgb_out(rgb[0]), .frame_start(fso[0]));
    hdmi_rom_pic_reader #(.IMG_W(4), .IMG_H(2), .H_START(6), .V_START(1)) u1 (
        .clk(clk), .rst(rst), .de_in(de), .hs_in(hs), .vs_in(vs), .rom_addr(addr[1]), .rom_data(rdat[1]),
        .de_out(deo[1]), .hs_out(hso[1]), .vs_out(vso[1]), .rgb_out(rgb[1]), .frame_start(fso[1]));
    hdmi_rom_pic_reader u2 (
        .clk(clk), .rst(rst), .de_in(de), .hs_in(hs), .vs_in(vs), .rom_addr(addr[2]), .rom_data(rdat[2]),
        .de_out(deo[2]), .hs_out(hso[2]), .vs_out(vso[2]), .rgb_out(rgb[2]), .frame_start(fso[2]));

    // Tagged ROM contents keep address 0 distinguishable from the black background.
    always @(posedge clk)
        for (int k = 0; k < 3; k++) rdat[k] <= {8'h5A, addr[k]};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h at %0t", name, act, want, $time);
        end
    endtask

    // Model: pixel position from line/pixel counts, address as (y-V)*W + (x-H).
    task automatic cyc(input logic r, input logic d, input logic h, input logic v);
        exp_t e;
        bit   rise, fall, win;
        int   yc, a;
        @(posedge clk);
        #1;
        rst = r; de = d; hs = h; vs = v;
        ea_cur = ea_next;
        e = '0;
        if (r) begin
            mx = 0; my = 0; synced = 0; pde = 0; pvs = 0;
            for (int k = 0; k < 3; k++) ea_next[k] = '0;
            if (q.size() >= 1) q[q.size()-1] = e;
            if (q.size() >= 2) q[q.size()-2] = e;
        end else begin
            rise = v && !pvs;
            fall = !d && pde;
            if (rise) synced = 1;
            yc = rise ? 0 : my;
            for (int k = 0; k < 3; k++) begin
                win = synced && d && mx >= hs_p[k] && mx < hs_p[k] + iw_p[k]
                      && yc >= vs_p[k] && yc < vs_p[k] + ih_p[k];
                a = (yc - vs_p[k]) * iw_p[k] + mx - hs_p[k];
                if (win) begin
                    e.rgb[k] = {8'h5A, a[15:0]};
                    ea_next[k] = a[15:0];
                end
            end
            e.de = d; e.hs = h; e.vs = v; e.fs = rise;
            mx = d ? mx + 1 : 0;
            my = rise ? 0 : (fall ? my + 1 : my);
            pde = d; pvs = v;
        end
        q.push_back(e);
    endtask

    task automatic line(input int npix, input int pre, input int post);
        cyc(0, 0, 1, 0);
        repeat (pre) cyc(0, 0, 0, 0);
        repeat (npix) cyc(0, 1, 0, 0);
        repeat (post) cyc(0, 0, 0, 0);
    endtask

    task automatic frame(input int nl, input int npix);
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 0);
        repeat (nl) line(npix, 1, 1);
    endtask

    always @(negedge clk) begin
        if (q.size() >= 4) begin
            me = q.pop_front();
            for (int k = 0; k < 3; k++) begin
                chk($sformatf("de_out%0d", k), 32'(deo[k]), 32'(me.de));
                chk($sformatf("hs_out%0d", k), 32'(hso[k]), 32'(me.hs));
                chk($sformatf("vs_out%0d", k), 32'(vso[k]), 32'(me.vs));
                chk($sformatf("frame_start%0d", k), 32'(fso[k]), 32'(me.fs));
                chk($sformatf("rgb_out%0d", k), 32'(rgb[k]), 32'(me.rgb[k]));
                chk($sformatf("rom_addr%0d", k), 32'(addr[k]), 32'(ea_cur[k]));
            end
        end
    end

    initial begin
        int nv, nl;
        rst = 1; de = 0; hs = 0; vs = 0;
        mx = 0; my = 0; synced = 0; pde = 0; pvs = 0;
        for (int k = 0; k < 3; k++) begin
            ea_next[k] = '0;
            ea_cur[k]  = '0;
        end
        repeat (4) cyc(1, 0, 0, 0);
        repeat (2) line(8, 1, 1);
        repeat (3) frame(4, 8);
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 0);
        line(8, 1, 1);
        cyc(0, 0, 1, 0);
        repeat (4) cyc(0, 1, 0, 0);
        cyc(1, 1, 0, 0);
        repeat (4) cyc(0, 1, 0, 0);
        cyc(0, 0, 0, 0);
        line(8, 1, 1);
        repeat (2) frame(4, 8);
        repeat (40) begin
            if ($urandom_range(0, 9) == 0) cyc(1, 1'($urandom_range(0, 1)), 0, 0);
            nv = $urandom_range(1, 2);
            for (int i = 0; i < nv; i++) cyc(0, $urandom_range(0, 3) == 0, 0, 1);
            cyc(0, 0, 0, 0);
            nl = $urandom_range(1, 5);
            for (int l = 0; l < nl; l++)
                line($urandom_range(1, 10), $urandom_range(0, 2), $urandom_range(0, 1));
        end
        // Full-size window: one-pixel lines reach y=487 cheaply, then one wide line crosses x=767.
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 0);
        repeat (487) begin
            cyc(0, 1, 0, 0);
            cyc(0, 0, 0, 0);
        end
        cyc(0, 0, 1, 0);
        repeat (800) cyc(0, 1, 0, 0);
        repeat (6) cyc(0, 0, 0, 0);
        @(negedge clk);
        #1;
        chk("full_last_addr", 32'(addr[2]), 32'h0000FFFF);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
